md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multiply/divide sequencer for the execute stage of the five-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo from E, holds the HI/LO register pair, and models fixed multi-cycle latency with a busy counter. Drives the decode-stage stall request whenever an instruction in D needs the unit while a request is starting or in flight. All four arithmetic operations are computed at issue; the counter only delays the HI/LO update.

## Interface
- MULT_CYCLES, default 5: busy cycles for mult/multu (legal 1..15).
- DIV_CYCLES, default 10: busy cycles for div/divu (legal 1..15).
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high; clears all state at the next rising edge.
- md_start_E  in  1  The E-stage instruction issues md_op_E this cycle.
- md_op_E  in  3  Operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val_E  in  32  Operand A: multiplicand, dividend, or mthi/mtlo data.
- rt_val_E  in  32  Operand B: multiplier or divisor.
- md_use_D  in  1  The D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  An operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stall_D  out  1  Freeze PC/IF-ID and insert a bubble into E.

## Operation
- States: IDLE and RUN. Counter cnt is 4 bits. The pending results pend_hi and pend_lo are 32 bits each.
- IDLE, with md_start_E=1 and op 1–4:
  - Compute pend_hi and pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, with md_start_E=1 and op 5 or 6: write rs_val_E into hi (op 5) or lo (op 6) at that edge. Stay in IDLE.
- IDLE, op 0 or 7, or md_start_E=0: no change.
- RUN: decrement cnt each edge. On the edge where cnt==1, copy pend_hi/pend_lo into hi/lo and go to IDLE.
- busy=1 exactly while in RUN.
- mult: 64-bit signed product; hi = bits 63:32, lo = bits 31:0.
- multu: 64-bit unsigned product; same HI/LO split.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, unsigned remainder in hi.
- Divisor 0 (div/divu): the full busy period still elapses, then hi/lo are left unchanged.
- md_start_E while busy=1 is ignored (no state change). stall_D guarantees this cannot occur in legal operation; the bench flags it as an error.
- stall_D = md_use_D & (busy | (md_start_E & md_op_E in 1..6)). This is purely combinational.
  - mfhi/mflo in D therefore wait until the final hi/lo value is in place; this block provides no forwarding of pending results.
- Reset, including mid-RUN, gives: state IDLE, cnt=0, busy=0, hi=0, lo=0, pend_hi=pend_lo=0. The in-flight result is discarded.
- Reset takes priority over any simultaneous md_start_E.

## Timing
- Reset values: busy=0, hi=0, lo=0. stall_D = 0 unless md_use_D & md_start_E with op 1..6.
- For mult/div issued at edge N (md_start_E high in the cycle before N), with latency L = MULT_CYCLES or DIV_CYCLES:
  - busy is high for cycles N..N+L-1.
  - hi/lo take the new value at edge N+L.
  - busy is low at edge N+L.
- Back-to-back: a new md_start_E may be accepted in the first cycle with busy=0, i.e. the cycle after edge N+L.
- mthi/mtlo: hi/lo update at the issuing edge. busy is never asserted.
- stall_D follows its inputs in the same cycle, with no registered delay.
- hi/lo change only at the completion edge, at an mthi/mtlo edge, or at reset.

## Test plan
- **Reset mid-op:** issue mult 3×4, assert reset at edge N+2 → busy=0, hi=lo=0 after that edge; the result is never written.
- **Signed mult:** 0xFFFFFFFE × 0x00000003 with defaults → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **Unsigned mult:** the same operands as multu → hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- **Signed div with negative dividend:** -7 / 2 → after 10 busy cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- **Divide-by-zero after mtlo/mthi:** mtlo 0x1234, then mthi 0x5678, then divu x/0 → hi=0x5678, lo=0x1234 immediately; they remain so after 10 busy cycles.
- **Stall and back-to-back:** hold md_use_D=1 while issuing mult → stall_D high in the issue cycle and all 5 busy cycles, low in the cycle after. A second mult issued in that cycle is accepted.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// ============================================================================
// Module   : md_unit_ctrl
// Purpose  : Multiply/divide sequencer for the execute stage of a five-stage
//            MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo from E,
//            owns the HI/LO register pair and models a fixed multi-cycle
//            latency with a busy counter. Results are computed at issue and
//            held in pending registers until the counter expires.
//
// Ports    : clk         in   pipeline clock, rising edge
//            reset       in   synchronous, active-high
//            md_start_E  in   E-stage instruction issues md_op_E this cycle
//            md_op_E     in   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,
//                             6 mtlo,7 reserved (none)
//            rs_val_E    in   operand A (multiplicand/dividend/mthi-mtlo data)
//            rt_val_E    in   operand B (multiplier/divisor)
//            md_use_D    in   D-stage instruction needs the unit
//            busy        out  operation in flight
//            hi, lo      out  HI/LO registers
//            stall_D     out  freeze PC/IF-ID, bubble into E
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,   // legal 1..15
    parameter int DIV_CYCLES  = 10   // legal 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_val_E,
    input  logic [31:0] rt_val_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_D
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] C_OP_NONE  = 3'd0;
    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    // ------------------------------------------------------------------
    // Arithmetic, evaluated on the E-stage operands every cycle
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_b_safe;
    logic [31:0] w_b_mag_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic        w_op_uses_unit;

    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // unsigned product equal to the two's-complement signed product.
    assign w_prod_s = {{32{rs_val_E[31]}}, rs_val_E} * {{32{rt_val_E[31]}}, rt_val_E};
    assign w_prod_u = {32'd0, rs_val_E} * {32'd0, rt_val_E};

    // Signed division is done on magnitudes so that truncation toward zero
    // and the remainder sign never depend on simulator operator semantics.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1, then
    // negation wraps back to 0x80000000 with remainder 0.
    assign w_a_neg      = rs_val_E[31];
    assign w_b_neg      = rt_val_E[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - rs_val_E) : rs_val_E;
    assign w_b_mag      = w_b_neg ? (32'd0 - rt_val_E) : rt_val_E;

    // A zero divisor is replaced by 1 purely to keep the divider defined;
    // its results are discarded in that case.
    assign w_div_zero   = (rt_val_E == 32'd0);
    assign w_b_safe     = w_div_zero ? 32'd1 : rt_val_E;
    assign w_b_mag_safe = w_div_zero ? 32'd1 : w_b_mag;

    assign w_uq         = rs_val_E / w_b_safe;
    assign w_ur         = rs_val_E % w_b_safe;
    assign w_sq_mag     = w_a_mag / w_b_mag_safe;
    assign w_sr_mag     = w_a_mag % w_b_mag_safe;
    assign w_sq         = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr         = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

    assign w_op_uses_unit = (md_op_E != C_OP_NONE) && (md_op_E != 3'd7);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            S_IDLE: begin
                if (md_start_E) begin
                    case (md_op_E)
                        C_OP_MULT: begin
                            pend_hi_d = w_prod_s[63:32];
                            pend_lo_d = w_prod_s[31:0];
                            cnt_d     = C_MULT_CNT;
                            state_d   = S_RUN;
                        end
                        C_OP_MULTU: begin
                            pend_hi_d = w_prod_u[63:32];
                            pend_lo_d = w_prod_u[31:0];
                            cnt_d     = C_MULT_CNT;
                            state_d   = S_RUN;
                        end
                        C_OP_DIV: begin
                            // Divide by zero: pend mirrors current HI/LO so the
                            // completion edge leaves them unchanged.
                            pend_hi_d = w_div_zero ? hi_q : w_sr;
                            pend_lo_d = w_div_zero ? lo_q : w_sq;
                            cnt_d     = C_DIV_CNT;
                            state_d   = S_RUN;
                        end
                        C_OP_DIVU: begin
                            pend_hi_d = w_div_zero ? hi_q : w_ur;
                            pend_lo_d = w_div_zero ? lo_q : w_uq;
                            cnt_d     = C_DIV_CNT;
                            state_d   = S_RUN;
                        end
                        C_OP_MTHI: hi_d = rs_val_E;
                        C_OP_MTLO: lo_d = rs_val_E;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                // Any md_start_E here is ignored; stall_D keeps it from
                // happening in a legal pipeline.
                if (cnt_q <= 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy    = (state_q == S_RUN);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // No forwarding of pending results: mfhi/mflo in D simply wait.
    assign stall_D = md_use_D & (busy | (md_start_E & w_op_uses_unit));

endmodule

`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
// ============================================================================
// Module   : tb_md_unit_ctrl
// Purpose  : Directed self-checking bench for md_unit_ctrl with default
//            latencies (mult 5, div 10). Inputs change 1 ns after the rising
//            edge; outputs are sampled there too, away from the edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit_ctrl;

    localparam int C_MULT_L = 5;
    localparam int C_DIV_L  = 10;

    logic        clk;
    logic        reset;
    logic        md_start_E;
    logic [2:0]  md_op_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_D;

    int n_checks;
    int n_fails;

    md_unit_ctrl #(
        .MULT_CYCLES (C_MULT_L),
        .DIV_CYCLES  (C_DIV_L)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .md_start_E (md_start_E),
        .md_op_E    (md_op_E),
        .rs_val_E   (rs_val_E),
        .rt_val_E   (rt_val_E),
        .md_use_D   (md_use_D),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .stall_D    (stall_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one cycle; returns 1 ns after the issuing edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start_E = 1'b1;
        md_op_E    = op;
        rs_val_E   = a;
        rt_val_E   = b;
        tick();
        md_start_E = 1'b0;
        md_op_E    = 3'd0;
    endtask

    // Called right after the issuing edge: busy must hold for lat cycles with
    // HI/LO untouched, then drop.
    task automatic wait_busy(input string tag, input int lat,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_hi_hold"}, hi, old_hi);
            check({tag, "_lo_hold"}, lo, old_lo);
            tick();
        end
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        md_start_E = 1'b0;
        md_op_E    = 3'd0;
        rs_val_E   = 32'd0;
        rt_val_E   = 32'd0;
        md_use_D   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        md_use_D = 1'b1;
        #1;
        check("rst_stall_idle", {31'd0, stall_D}, 32'd0);
        md_start_E = 1'b1;
        md_op_E    = 3'd7;
        #1;
        check("stall_reserved_op", {31'd0, stall_D}, 32'd0);
        md_op_E = 3'd5;
        #1;
        check("stall_mthi_issue", {31'd0, stall_D}, 32'd1);
        md_start_E = 1'b0;
        md_op_E    = 3'd0;
        md_use_D   = 1'b0;
        #1;

        // ---------------- reset mid-op ----------------
        issue(3'd5, 32'h0000_00AA, 32'd0);          // mthi so reset visibly clears hi
        check("mthi_hi", hi, 32'h0000_00AA);
        check("mthi_nobusy", {31'd0, busy}, 32'd0);
        issue(3'd1, 32'd3, 32'd4);                  // edge N
        check("rmid_busy", {31'd0, busy}, 32'd1);
        tick();                                     // edge N+1
        reset = 1'b1;
        tick();                                     // edge N+2 with reset
        reset = 1'b0;
        check("rmid_busy_clr", {31'd0, busy}, 32'd0);
        check("rmid_hi", hi, 32'd0);
        check("rmid_lo", lo, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("rmid_lo_never", lo, 32'd0);
        check("rmid_hi_never", hi, 32'd0);

        // ---------------- signed mult ----------------
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_busy("mult", C_MULT_L, 32'd0, 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // ---------------- unsigned mult ----------------
        issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_busy("multu", C_MULT_L, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // ---------------- signed div, negative dividend ----------------
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_busy("div", C_DIV_L, 32'h0000_0002, 32'hFFFF_FFFA);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // ---------------- signed div overflow corner ----------------
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divovf", C_DIV_L, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0000_0000);

        // ---------------- divu ----------------
        issue(3'd4, 32'd100, 32'd7);
        wait_busy("divu", C_DIV_L, 32'd0, 32'h8000_0000);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // ---------------- divide by zero after mtlo/mthi ----------------
        issue(3'd6, 32'h0000_1234, 32'd0);
        check("mtlo_lo", lo, 32'h0000_1234);
        issue(3'd5, 32'h0000_5678, 32'd0);
        check("mthi_hi2", hi, 32'h0000_5678);
        check("mthi_lo2", lo, 32'h0000_1234);
        issue(3'd4, 32'h0000_0099, 32'd0);
        wait_busy("divz", C_DIV_L, 32'h0000_5678, 32'h0000_1234);
        check("divz_hi", hi, 32'h0000_5678);
        check("divz_lo", lo, 32'h0000_1234);

        // ---------------- stall and back-to-back ----------------
        md_use_D   = 1'b1;
        md_start_E = 1'b1;
        md_op_E    = 3'd1;
        rs_val_E   = 32'd6;
        rt_val_E   = 32'd7;
        #1;
        check("stall_issue", {31'd0, stall_D}, 32'd1);
        tick();
        md_start_E = 1'b0;
        md_op_E    = 3'd0;
        for (int i = 0; i < C_MULT_L; i++) begin
            #1;
            check("stall_busy", {31'd0, stall_D}, 32'd1);
            tick();
        end
        #1;
        check("stall_after", {31'd0, stall_D}, 32'd0);
        check("b2b_first_lo", lo, 32'd42);
        check("b2b_first_hi", hi, 32'd0);
        md_use_D = 1'b0;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // accepted in first idle cycle
        wait_busy("b2b", C_MULT_L, 32'd0, 32'd42);
        check("b2b_lo", lo, 32'd1);
        check("b2b_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
